// File: rtl/s_cntr.sv
// s_cntr: enable-gated binary up-counter for the ADPLL datapath, built as one
// async-clear D flip-flop per bit with a synchronous carry-chain next state.

module s_cntr_dff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) q <= 1'b0;
    else       q <= d;
  end

endmodule

module s_cntr #(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in,
  output logic [WIDTH-1:0] o_out
);

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] d;
  logic             at_max;
  logic             hold;

  // carry[b] is high when counting is enabled and every bit below b is one
  assign carry[0] = i_in;
  assign at_max   = &o_out;
  assign hold     = (SATURATE != 0) && at_max;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    if (b < WIDTH - 1) begin : g_carry
      assign carry[b+1] = carry[b] & o_out[b];
    end

    assign toggle[b] = carry[b] & ~hold;
    assign d[b]      = o_out[b] ^ toggle[b];

    s_cntr_dff u_ff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .d     (d[b]),
      .q     (o_out[b])
    );
  end

endmodule

// File: tb/tb_s_cntr.sv
// tb_s_cntr: checks a wrapping and a saturating 4-bit s_cntr against a simple
// arithmetic model every cycle, plus hand-computed values at key points.
`timescale 1ns/1ps

module tb_s_cntr;

  logic       i_clk;
  logic       i_rst;
  logic       i_in;
  logic [3:0] out_wrap;
  logic [3:0] out_sat;

  int checks   = 0;
  int failures = 0;
  int model_wrap = 0;
  int model_sat  = 0;
  bit compare_on = 1'b0;

  s_cntr #(.WIDTH(4), .SATURATE(0)) u_wrap (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_in  (i_in),
    .o_out (out_wrap)
  );

  s_cntr #(.WIDTH(4), .SATURATE(1)) u_sat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_in  (i_in),
    .o_out (out_sat)
  );

  // 200 MHz clock
  initial begin
    i_clk = 1'b0;
    forever #2.5 i_clk = ~i_clk;
  end

  // Model: count of enabled edges since reset, modulo 16 or clamped at 15
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      model_wrap = 0;
      model_sat  = 0;
    end else if (i_in) begin
      model_wrap = (model_wrap + 1) % 16;
      model_sat  = (model_sat >= 15) ? 15 : model_sat + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (compare_on) begin
      checkOutput("model_wrap", int'(out_wrap), model_wrap);
      checkOutput("model_sat", int'(out_sat), model_sat);
    end
  end

  task automatic stepEdge;
    @(posedge i_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic in_val, input int edges);
    i_in = in_val;
    repeat (edges) stepEdge();
  endtask

  // Reset pulse placed between edges; the count must clear before the next edge
  task automatic pulseReset;
    i_rst = 1'b1;
    #1;
    checkOutput("rst_wrap", int'(out_wrap), 0);
    checkOutput("rst_sat", int'(out_sat), 0);
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b0;
    i_in  = 1'b0;
    compare_on = 1'b1;

    applyStimulus(1'b0, 20);
    checkOutput("powerup_wrap", int'(out_wrap), 0);
    checkOutput("powerup_sat", int'(out_sat), 0);

    applyStimulus(1'b1, 1);
    checkOutput("step1", int'(out_wrap), 1);
    applyStimulus(1'b1, 1);
    checkOutput("step2", int'(out_wrap), 2);
    applyStimulus(1'b1, 1);
    checkOutput("step3", int'(out_wrap), 3);
    applyStimulus(1'b1, 1);
    checkOutput("step4", int'(out_wrap), 4);
    applyStimulus(1'b0, 5);
    checkOutput("hold4_wrap", int'(out_wrap), 4);
    checkOutput("hold4_sat", int'(out_sat), 4);

    i_in = 1'b0;
    pulseReset();
    for (int e = 1; e <= 17; e++) begin
      applyStimulus(1'b1, 1);
      if (e == 15) begin
        checkOutput("edge15_wrap", int'(out_wrap), 15);
        checkOutput("edge15_sat", int'(out_sat), 15);
      end else if (e == 16) begin
        checkOutput("edge16_wrap", int'(out_wrap), 0);
        checkOutput("edge16_sat", int'(out_sat), 15);
      end else if (e == 17) begin
        checkOutput("edge17_wrap", int'(out_wrap), 1);
        checkOutput("edge17_sat", int'(out_sat), 15);
      end
    end
    applyStimulus(1'b0, 2);

    pulseReset();
    applyStimulus(1'b1, 9);
    checkOutput("count9_wrap", int'(out_wrap), 9);
    checkOutput("count9_sat", int'(out_sat), 9);
    i_in = 1'b0;
    pulseReset();
    applyStimulus(1'b1, 1);
    checkOutput("after_rst_wrap", int'(out_wrap), 1);
    checkOutput("after_rst_sat", int'(out_sat), 1);

    i_in = 1'b0;
    pulseReset();
    for (int e = 0; e < 8; e++) begin
      applyStimulus((e % 2 == 0) ? 1'b1 : 1'b0, 1);
    end
    checkOutput("alternate_wrap", int'(out_wrap), 4);
    checkOutput("alternate_sat", int'(out_sat), 4);

    applyStimulus(1'b0, 2);
    compare_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
